// File: rtl/gear_edc_ctrl.sv
// Sequencing controller around a lower-part-approximate GeAr adder: evaluates the
// approximate sum, flags inexact results, optionally corrects them, and keeps saturating stats.
module gear_edc_ctrl #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             corr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_err,
    output logic             out_corrected,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int L  = APPROX_BITS;
    localparam int HW = WIDTH - APPROX_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] CORR = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             corr_en_reg;

    logic [HW:0]      hi_sum;
    logic [L-1:0]     lo_xor;
    logic [WIDTH:0]   approx_sum;
    logic [WIDTH:0]   exact_sum;
    logic             err;
    logic             deliver;

    // Low part carries nothing upward: per-bit XOR only.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi = gi + 1) begin : g_lo
            assign lo_xor[gi] = a_reg[gi] ^ b_reg[gi];
        end
    endgenerate

    assign hi_sum     = {1'b0, a_reg[WIDTH-1:L]} + {1'b0, b_reg[WIDTH-1:L]};
    assign approx_sum = {hi_sum, lo_xor};
    assign exact_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    // Any generated low-part carry is exactly what the approximation drops.
    assign err        = |(a_reg[L-1:0] & b_reg[L-1:0]);

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign deliver   = (state_reg == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            corr_en_reg   <= 1'b0;
            out_sum       <= '0;
            out_err       <= 1'b0;
            out_corrected <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg       <= in_a;
                        b_reg       <= in_b;
                        corr_en_reg <= corr_en;
                        state_reg   <= EVAL;
                    end
                end
                EVAL: begin
                    out_err <= err;
                    if (err && corr_en_reg) begin
                        state_reg <= CORR;
                    end else begin
                        out_sum       <= approx_sum;
                        out_corrected <= 1'b0;
                        state_reg     <= DONE;
                    end
                end
                CORR: begin
                    out_sum       <= exact_sum;
                    out_corrected <= 1'b1;
                    state_reg     <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    // Clear takes priority over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if (clr_cnt) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if (deliver) begin
            if (op_cnt != CNT_MAX) begin
                op_cnt <= op_cnt + 1'b1;
            end
            if (out_err && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gear_edc_ctrl.sv
// Directed bench for gear_edc_ctrl (WIDTH=8, APPROX_BITS=4, CNT_W=4) with hand-computed results.
module tb_gear_edc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       corr_en;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       out_err;
    logic       out_corrected;
    logic       clr_cnt;
    logic [3:0] op_cnt;
    logic [3:0] err_cnt;

    int tests_run;
    int tests_failed;

    gear_edc_ctrl #(
        .WIDTH      (8),
        .APPROX_BITS(4),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .corr_en      (corr_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_err      (out_err),
        .out_corrected(out_corrected),
        .clr_cnt      (clr_cnt),
        .op_cnt       (op_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, scramble the inputs, then count edges until out_valid.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ce,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        corr_en  = ce;
        tick();
        in_valid = 1'b0;
        in_a     = 8'hA5;
        in_b     = 8'h5A;
        corr_en  = ~ce;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ce, input logic [8:0] exp_sum, input logic exp_err,
                          input logic exp_corr, input int exp_lat);
        int lat;
        issue(a, b, ce, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_err"}, out_err, exp_err);
        check({tag, "_corr"}, out_corrected, exp_corr);
        tick();
        check({tag, "_done"}, out_valid, 1'b0);
        $display("[TB] op %s a=%02h b=%02h ce=%0d sum=%03h err=%0d corr=%0d lat=%0d op_cnt=%0d err_cnt=%0d",
                 tag, a, b, ce, exp_sum, exp_err, exp_corr, lat, op_cnt, err_cnt);
    endtask

    initial begin
        int lat;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        corr_en   = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;

        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 9'h000);
        check("rst_out_err", out_err, 1'b0);
        check("rst_op_cnt", op_cnt, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        run_op("t1", 8'h35, 8'h42, 1'b1, 9'h077, 1'b0, 1'b0, 2);
        check("t1_op_cnt", op_cnt, 4'd1);
        check("t1_err_cnt", err_cnt, 4'd0);

        run_op("t2a", 8'h0F, 8'h01, 1'b0, 9'h00E, 1'b1, 1'b0, 2);
        run_op("t2b", 8'h0F, 8'h01, 1'b1, 9'h010, 1'b1, 1'b1, 3);
        check("t2_err_cnt", err_cnt, 4'd2);
        check("t2_op_cnt", op_cnt, 4'd3);

        run_op("t3a", 8'hFF, 8'hFF, 1'b0, 9'h1E0, 1'b1, 1'b0, 2);
        run_op("t3b", 8'hFF, 8'hFF, 1'b1, 9'h1FE, 1'b1, 1'b1, 3);
        check("t3_op_cnt", op_cnt, 4'd5);
        check("t3_err_cnt", err_cnt, 4'd4);

        // Backpressure: hold result in DONE for 5 cycles while a new op is offered.
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, lat);
        check("bp_lat", lat, 2);
        in_valid = 1'b1;
        in_a     = 8'h77;
        in_b     = 8'h88;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_sum", out_sum, 9'h046);
            check("bp_err", out_err, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_delivered", out_valid, 1'b0);
        check("bp_op_cnt", op_cnt, 4'd6);
        tick();
        tick();
        check("bp_no_extra_valid", out_valid, 1'b0);
        check("bp_op_cnt_once", op_cnt, 4'd6);
        $display("[TB] op backpressure sum=046 op_cnt=%0d", op_cnt);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_op_cnt", op_cnt, 4'd0);
        check("clr_err_cnt", err_cnt, 4'd0);

        // Saturation: 17 erroring ops on 4-bit counters.
        for (int i = 0; i < 17; i++) begin
            run_op("sat", 8'h0F, 8'h01, 1'b0, 9'h00E, 1'b1, 1'b0, 2);
        end
        check("sat_op_cnt", op_cnt, 4'd15);
        check("sat_err_cnt", err_cnt, 4'd15);

        issue(8'h0F, 8'h01, 1'b0, lat);
        check("clrdel_lat", lat, 2);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clrdel_delivered", out_valid, 1'b0);
        check("clrdel_op_cnt", op_cnt, 4'd0);
        check("clrdel_err_cnt", err_cnt, 4'd0);
        $display("[TB] op clear-on-delivery op_cnt=%0d err_cnt=%0d", op_cnt, err_cnt);

        // Reset during CORR discards the operation and clears everything.
        run_op("pre_rst", 8'h0F, 8'h01, 1'b0, 9'h00E, 1'b1, 1'b0, 2);
        in_valid = 1'b1;
        in_a     = 8'h0F;
        in_b     = 8'h01;
        corr_en  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_corr_valid", out_valid, 1'b0);
        check("rst_corr_sum", out_sum, 9'h000);
        check("rst_corr_op_cnt", op_cnt, 4'd0);
        check("rst_corr_err_cnt", err_cnt, 4'd0);
        check("rst_corr_in_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        run_op("post_rst", 8'h35, 8'h42, 1'b0, 9'h077, 1'b0, 1'b0, 2);
        check("post_rst_op_cnt", op_cnt, 4'd1);
        check("post_rst_err_cnt", err_cnt, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
